// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
//
// Purpose:
//   Shares one single-ported external SRAM between the instruction-fetch (IF)
//   and data-memory (MEM) pipeline stages. Each access is sequenced with a
//   fixed wait-state count; read data returns with a one-cycle ready pulse.
//   A combinational freeze stalls all pipeline registers and the PC while any
//   request is outstanding.
//
// Handshake:
//   A requester raises its request (if_req, mem_r_en/mem_w_en) and holds it
//   together with address/data until it sees its one-cycle ready pulse. Read
//   data is valid in the ready cycle and is held afterwards until the next
//   completed read for the same requester. A request dropped mid-access
//   still completes and still pulses ready.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and byte address
//   if_rdata/if_ready        fetched word and completion pulse
//   mem_r_en/mem_w_en        data read / write request (both high = write)
//   mem_addr/mem_wdata       data byte address and store data
//   mem_rdata/mem_ready      load data and completion pulse
//   freeze                   global pipeline stall
//   sram_addr/wdata/rdata    SRAM word address and data buses
//   sram_we_n/sram_oe_n      SRAM write strobe / output enable, active low
//   dbg_state_o              current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests are granted to
//                       the requester that was not granted last; otherwise
//                       MEM always wins over IF.
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SRAM_AW     = 17,
  parameter int WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [DATA_W-1:0]  if_rdata,
  output logic               if_ready,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                owner_mem_q;
  logic                write_q;
  logic                if_ready_q;
  logic                mem_ready_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic [SRAM_AW-1:0]  sram_addr_q;
  logic [DATA_W-1:0]   sram_wdata_q;
  logic                we_n_q;
  logic                oe_n_q;

  logic                mem_pend;
  logic                any_req;
  logic                grant_mem_d;
  logic                grant_write_d;
  logic [SRAM_AW-1:0]  grant_addr_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_grant_mem_q;
`endif

  // Byte-address bits outside the SRAM word field are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:SRAM_AW+2], if_addr[1:0],
                              mem_addr[ADDR_W-1:SRAM_AW+2], mem_addr[1:0]};

  // Grant decision, evaluated only when the FSM is in IDLE.
  always_comb begin
    mem_pend      = mem_r_en | mem_w_en;
    any_req       = mem_pend | if_req;
`ifdef ARB_ROUND_ROBIN_EN
    // With both pending, the side that was not served last wins.
    grant_mem_d   = mem_pend & (~if_req | ~last_grant_mem_q);
`else
    grant_mem_d   = mem_pend;
`endif
    grant_write_d = grant_mem_d & mem_w_en;
    grant_addr_d  = grant_mem_d ? mem_addr[SRAM_AW+1:2] : if_addr[SRAM_AW+1:2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      owner_mem_q      <= 1'b0;
      write_q          <= 1'b0;
      if_ready_q       <= 1'b0;
      mem_ready_q      <= 1'b0;
      if_rdata_q       <= '0;
      mem_rdata_q      <= '0;
      sram_addr_q      <= '0;
      sram_wdata_q     <= '0;
      we_n_q           <= 1'b1;
      oe_n_q           <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_mem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          if (any_req) begin
            // Latch everything now so input changes during the access are ignored.
            owner_mem_q <= grant_mem_d;
            write_q     <= grant_write_d;
            sram_addr_q <= grant_addr_d;
            if (grant_mem_d) begin
              sram_wdata_q <= mem_wdata;
            end
            we_n_q  <= ~grant_write_d;
            oe_n_q  <= grant_write_d;
            cnt_q   <= '0;
            state_q <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_mem_q <= grant_mem_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == CNT_LAST) begin
            we_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            if (!write_q) begin
              if (owner_mem_q) begin
                mem_rdata_q <= sram_rdata;
              end else begin
                if_rdata_q <= sram_rdata;
              end
            end
            if (owner_mem_q) begin
              mem_ready_q <= 1'b1;
            end else begin
              if_ready_q <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ready    = if_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_ready   = mem_ready_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign dbg_state_o = state_q;

  // The ready pulse releases the stall in the very cycle it is seen.
  assign freeze = (mem_pend & ~mem_ready_q) | (if_req & ~if_ready_q);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_access_arbiter
//
// Directed bench for sram_access_arbiter (WAIT_CYCLES=4). A transaction-level
// model tracks the one access in flight (owner, word, op, start cycle) and
// derives strobes, ready pulses, read data and freeze per cycle; a compare
// process checks the DUT against it at every falling edge. Directed tests
// add literal expectations for latency, data and grant order.
// -----------------------------------------------------------------------------
module tb_sram_access_arbiter;

  localparam int W = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, mem_r_en, mem_w_en, freeze, if_ready, mem_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_rdata, mem_rdata;
  logic [31:0] sram_wdata, sram_rdata;
  logic [16:0] sram_addr;
  logic        sram_we_n, sram_oe_n;
  logic [1:0]  dbg_state;
  logic        mem_clr;

  sram_access_arbiter #(
    .DATA_W(32), .ADDR_W(32), .SRAM_AW(17), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .dbg_state_o(dbg_state)
  );

  // ---------------- SRAM device stub ----------------
  function automatic logic [31:0] init_word(input int w);
    if (w == 4) return 32'h8C01_0000;
    return 32'hA5A5_A500 | 32'(w & 255);
  endfunction

  logic [31:0] sram_mem     [0:255];
  logic        sram_written [0:255];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) sram_written[i] <= 1'b0;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr[7:0]]     <= sram_wdata;
      sram_written[sram_addr[7:0]] <= 1'b1;
    end
  end

  assign sram_rdata = sram_oe_n ? 32'hFFFF_FFFF :
                      (sram_written[sram_addr[7:0]] ? sram_mem[sram_addr[7:0]]
                                                    : init_word(int'(sram_addr[7:0])));

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // ---------------- transaction-level model ----------------
  bit          acc_valid;
  int          acc_start;
  bit          acc_mem;
  int          acc_word;
  bit          acc_write;
  logic [31:0] acc_wdata;
  logic [31:0] exp_if_rdata, exp_mem_rdata;
  bit          last_mem;
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  int k;
  bit in_acc, done, e_if_rdy, e_mem_rdy, mp, gm;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe_n", 32'(sram_oe_n), 32'd1);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_mem_ready", 32'(mem_ready), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      check("rst_sram_wdata", sram_wdata, 32'd0);
      acc_valid     = 1'b0;
      exp_if_rdata  = 32'd0;
      exp_mem_rdata = 32'd0;
      last_mem      = 1'b0;
    end else begin
      k      = cyc;
      in_acc = acc_valid && (k >= acc_start + 1) && (k <= acc_start + W);
      done   = acc_valid && (k == acc_start + W + 1);
      if (done) begin
        if (acc_write)    ref_mem[acc_word] = acc_wdata;
        else if (acc_mem) exp_mem_rdata = ref_read(acc_word);
        else              exp_if_rdata  = ref_read(acc_word);
      end
      e_if_rdy  = done && !acc_mem;
      e_mem_rdy = done && acc_mem;
      check("we_n", 32'(sram_we_n), 32'(!(in_acc && acc_write)));
      check("oe_n", 32'(sram_oe_n), 32'(!(in_acc && !acc_write)));
      check("if_ready", 32'(if_ready), 32'(e_if_rdy));
      check("mem_ready", 32'(mem_ready), 32'(e_mem_rdy));
      check("if_rdata", if_rdata, exp_if_rdata);
      check("mem_rdata", mem_rdata, exp_mem_rdata);
      check("freeze", 32'(freeze),
            32'(((mem_r_en | mem_w_en) & !e_mem_rdy) | (if_req & !e_if_rdy)));
      if (in_acc) check("sram_addr", 32'(sram_addr), 32'(acc_word));
      if (in_acc && acc_write) check("sram_wdata", sram_wdata, acc_wdata);
      if (done) begin
        acc_valid = 1'b0;
      end else if (!acc_valid) begin
        mp = mem_r_en | mem_w_en;
        if (mp | if_req) begin
          gm        = mp && (!RR || !if_req || !last_mem);
          acc_mem   = gm;
          acc_word  = gm ? int'(mem_addr[18:2]) : int'(if_addr[18:2]);
          acc_write = gm && mem_w_en;
          acc_wdata = mem_wdata;
          acc_start = k;
          acc_valid = 1'b1;
          last_mem  = gm;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input bit want_mem, input int max_cyc, output int seen,
                            output int frz, output int we_c, output int oe_c,
                            output logic [31:0] saddr, output logic frz_rdy);
    bit found = 1'b0;
    seen = -1; frz = 0; we_c = 0; oe_c = 0; saddr = 32'd0; frz_rdy = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!sram_we_n) we_c++;
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n || !sram_oe_n) saddr = 32'(sram_addr);
      if (want_mem ? mem_ready : if_ready) begin
        found = 1'b1; seen = cyc; frz_rdy = freeze;
      end else if (freeze) begin
        frz++;
      end
      @(posedge clk); #1;
      if (found) begin
        if (want_mem) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
        else if_req = 1'b0;
        break;
      end
    end
    check(want_mem ? "mem_ready_seen" : "if_ready_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_both(input int max_cyc, output int if_seen, output int mem_seen);
    if_seen = -1; mem_seen = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (if_ready && if_seen < 0) if_seen = cyc;
      if (mem_ready && mem_seen < 0) mem_seen = cyc;
      @(posedge clk); #1;
      if (if_seen >= 0) if_req = 1'b0;
      if (mem_seen >= 0) mem_r_en = 1'b0;
      if (if_seen >= 0 && mem_seen >= 0) break;
    end
  endtask

  // ---------------- directed stimulus ----------------
  int          c0, seen, frz, we_c, oe_c, if_seen, mem_seen, last_seen;
  logic [31:0] saddr;
  logic        frz_rdy;
  int          order[$];
  int          exp_order[4];

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // 1: fetch after reset
    rst = 1'b1; mem_clr = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    wait_ready(1'b0, 20, seen, frz, we_c, oe_c, saddr, frz_rdy);
    check("t1_ready_cycle", 32'(seen), 32'd5);
    check("t1_freeze_cycles", 32'(frz), 32'd5);
    check("t1_freeze_at_ready", 32'(frz_rdy), 32'd0);
    check("t1_oe_cycles", 32'(oe_c), 32'd4);
    check("t1_sram_addr", saddr, 32'h4);
    check("t1_if_rdata", if_rdata, 32'h8C01_0000);

    // 1b: fetch dropped mid-access still completes
    c0 = cyc; if_req = 1'b1; if_addr = 32'h20;
    @(posedge clk); #1; @(posedge clk); #1;
    if_req = 1'b0;
    wait_ready(1'b0, 20, seen, frz, we_c, oe_c, saddr, frz_rdy);
    check("t1b_ready_cycle", 32'(seen - c0), 32'd5);
    check("t1b_if_rdata", if_rdata, 32'hA5A5_A508);

    // 2: write then read back
    c0 = cyc; mem_w_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
    wait_ready(1'b1, 20, seen, frz, we_c, oe_c, saddr, frz_rdy);
    check("t2_w_ready_cycle", 32'(seen - c0), 32'd5);
    check("t2_we_cycles", 32'(we_c), 32'd4);
    check("t2_w_oe_cycles", 32'(oe_c), 32'd0);
    check("t2_w_sram_addr", saddr, 32'h10);
    c0 = cyc; mem_r_en = 1'b1; mem_addr = 32'h40;
    wait_ready(1'b1, 20, seen, frz, we_c, oe_c, saddr, frz_rdy);
    check("t2_r_ready_cycle", 32'(seen - c0), 32'd5);
    check("t2_mem_rdata", mem_rdata, 32'hDEAD_BEEF);

    // 3: simultaneous requests
    c0 = cyc; if_req = 1'b1; if_addr = 32'h10; mem_r_en = 1'b1; mem_addr = 32'h40;
    wait_both(30, if_seen, mem_seen);
    check("t3_mem_ready_cycle", 32'(mem_seen - c0), RR ? 32'd11 : 32'd5);
    check("t3_if_ready_cycle", 32'(if_seen - c0), RR ? 32'd5 : 32'd11);
    check("t3_if_rdata", if_rdata, 32'h8C01_0000);
    check("t3_mem_rdata", mem_rdata, 32'hDEAD_BEEF);

    // 4: both held over four grants (1 = MEM, 0 = IF)
    exp_order = RR ? '{0, 1, 0, 1} : '{1, 1, 1, 1};
    c0 = cyc; last_seen = -1; order.delete();
    if_req = 1'b1; mem_r_en = 1'b1;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(negedge clk);
      if (mem_ready) begin order.push_back(1); last_seen = cyc; end
      if (if_ready)  begin order.push_back(0); last_seen = cyc; end
      @(posedge clk); #1;
    end
    if_req = 1'b0; mem_r_en = 1'b0;
    check("t4_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
    check("t4_fourth_ready_cycle", 32'(last_seen - c0), 32'd23);

    // 5: reset during a write at cnt=2, then the held request is re-served
    mem_w_en = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h1234_5678;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t5_we_n_in_reset", 32'(sram_we_n), 32'd1);
    check("t5_ready_in_reset", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_ready(1'b1, 20, seen, frz, we_c, oe_c, saddr, frz_rdy);
    check("t5_ready_cycle", 32'(seen), 32'd5);
    check("t5_we_cycles", 32'(we_c), 32'd4);
    c0 = cyc; mem_r_en = 1'b1; mem_addr = 32'h80;
    wait_ready(1'b1, 20, seen, frz, we_c, oe_c, saddr, frz_rdy);
    check("t5_r_ready_cycle", 32'(seen - c0), 32'd5);
    check("t5_mem_rdata", mem_rdata, 32'h1234_5678);

    // 6: misaligned address, address changed mid-access
    c0 = cyc; mem_r_en = 1'b1; mem_addr = 32'h43;
    @(posedge clk); #1; @(posedge clk); #1;
    mem_addr = 32'h100;
    wait_ready(1'b1, 20, seen, frz, we_c, oe_c, saddr, frz_rdy);
    check("t6_ready_cycle", 32'(seen - c0), 32'd5);
    check("t6_sram_addr", saddr, 32'h10);
    check("t6_mem_rdata", mem_rdata, 32'hDEAD_BEEF);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
